jtframe_rgb_interp_pipe: RTL and testbench

Parametrised, pipelined pixel interpolator for the scan-doubler/rotation video path. Blends a current and previous pixel of any channel count and channel width by a fractional weight, with selectable linear, nearest or bypass mode. Advances on a pixel clock enable and carries blank and valid alongside the data with fixed latency. It replaces the fixed 5-6-5, always-linear interpolator feeding the video output mux.

---
 rtl/jtframe_interp_pkg.sv | 12 +
 rtl/jtframe_interp_ch.sv | 88 ++++++++
 rtl/jtframe_rgb_interp_pipe.sv | 90 +++++++++
 tb/tb_jtframe_rgb_interp_pipe.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_interp_pkg.sv
// Shared definitions for the RGB interpolation pipeline: blend mode encoding.
package jtframe_interp_pkg;

  // Mode code 3 has no dedicated behaviour and blends like linear mode.
  typedef enum logic [1:0] {
    INTERP_LINEAR  = 2'd0,
    INTERP_NEAREST = 2'd1,
    INTERP_BYPASS  = 2'd2,
    INTERP_LINEAR3 = 2'd3
  } interp_mode_e;

endpackage

// File: rtl/jtframe_interp_ch.sv
// One colour channel of the interpolator: the weighted products, then the
// rounded/saturated sum followed by the mode and blank selection.
module jtframe_interp_ch
  import jtframe_interp_pkg::*;
#(
  parameter int DW = 8,
  parameter int FW = 8
) (
  input  logic          clk_sys,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [FW:0]   fc,
  input  interp_mode_e  mode,
  input  logic          blank,
  input  logic [DW-1:0] cur,
  input  logic [DW-1:0] prev,
  output logic [DW-1:0] dout
);

  localparam int PW = DW + FW + 1;
  localparam int SW = DW + FW + 2;
  localparam logic [FW:0]   FULL  = (FW+1)'(1) << FW;
  localparam logic [FW:0]   HALFW = (FW+1)'(1) << (FW-1);
  localparam logic [SW-1:0] ROUND = SW'(1) << (FW-1);
  localparam logic [SW-1:0] MAXV  = SW'({DW{1'b1}});

  logic [FW:0]   w_prev;
  logic [PW-1:0] prod_cur;
  logic [PW-1:0] prod_prev;
  interp_mode_e  s2_mode;
  logic          s2_blank;
  logic          s2_near_cur;
  logic [DW-1:0] s2_cur;
  logic [DW-1:0] s2_prev;
  logic [SW-1:0] sum;
  logic [SW-1:0] shifted;
  logic [DW-1:0] lin;
  logic [DW-1:0] sel;

  assign w_prev = FULL - fc;

  // Stage 2: both weighted products, plus the nearest-neighbour decision and
  // the raw pixels that the non-linear modes need one stage later.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      prod_cur    <= '0;
      prod_prev   <= '0;
      s2_mode     <= INTERP_LINEAR;
      s2_blank    <= 1'b0;
      s2_near_cur <= 1'b0;
      s2_cur      <= '0;
      s2_prev     <= '0;
    end else if (cen) begin
      prod_cur    <= PW'(cur) * PW'(fc);
      prod_prev   <= PW'(prev) * PW'(w_prev);
      s2_mode     <= mode;
      s2_blank    <= blank;
      s2_near_cur <= (fc >= HALFW);
      s2_cur      <= cur;
      s2_prev     <= prev;
    end
  end

  assign sum     = SW'(prod_cur) + SW'(prod_prev) + ROUND;
  assign shifted = sum >> FW;
  assign lin     = (shifted > MAXV) ? {DW{1'b1}} : shifted[DW-1:0];

  // Pick the result for the carried mode; blanked pixels are forced black.
  always_comb begin
    sel = lin;
    case (s2_mode)
      INTERP_NEAREST: sel = s2_near_cur ? s2_cur : s2_prev;
      INTERP_BYPASS:  sel = s2_cur;
      default:        sel = lin;
    endcase
    if (s2_blank) sel = '0;
  end

  // Stage 3: register the selected channel value straight onto the output.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dout <= '0;
    end else if (cen) begin
      dout <= sel;
    end
  end

endmodule

// File: rtl/jtframe_rgb_interp_pipe.sv
// Three-stage pixel interpolator blending the current and previous pixel by a
// fractional weight, with per-pixel mode, blank and valid travelling alongside.
module jtframe_rgb_interp_pipe
  import jtframe_interp_pkg::*;
#(
  parameter int CH = 3,
  parameter int DW = 8,
  parameter int FW = 8
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             pxl_cen,
  input  logic             in_valid,
  input  logic             blank,
  input  logic [1:0]       mode,
  input  logic [FW:0]      frac,
  input  logic [CH*DW-1:0] rgb_in,
  input  logic [CH*DW-1:0] rgb_in_prev,
  output logic [CH*DW-1:0] rgb_out,
  output logic             out_valid,
  output logic             out_blank
);

  localparam logic [FW:0] FULL = (FW+1)'(1) << FW;

  logic [FW:0]      fc_clamped;
  logic             s1_valid;
  logic             s1_blank;
  interp_mode_e     s1_mode;
  logic [FW:0]      s1_fc;
  logic [CH*DW-1:0] s1_cur;
  logic [CH*DW-1:0] s1_prev;
  logic             s2_valid;
  logic             s2_blank;

  assign fc_clamped = (frac > FULL) ? FULL : frac;

  // Stage 1: capture the pixel and its side information, clamping the weight.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_blank <= 1'b0;
      s1_mode  <= INTERP_LINEAR;
      s1_fc    <= '0;
      s1_cur   <= '0;
      s1_prev  <= '0;
    end else if (pxl_cen) begin
      s1_valid <= in_valid;
      s1_blank <= blank;
      s1_mode  <= interp_mode_e'(mode);
      s1_fc    <= fc_clamped;
      s1_cur   <= rgb_in;
      s1_prev  <= rgb_in_prev;
    end
  end

  // Valid/blank delay line matching the two channel stages.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_blank  <= 1'b0;
      out_valid <= 1'b0;
      out_blank <= 1'b0;
    end else if (pxl_cen) begin
      s2_valid  <= s1_valid;
      s2_blank  <= s1_blank;
      out_valid <= s2_valid;
      out_blank <= s2_blank;
    end
  end

  // Channel 0 sits in the most significant bits of every packed bus.
  for (genvar i = 0; i < CH; i++) begin : g_ch
    jtframe_interp_ch #(
      .DW (DW),
      .FW (FW)
    ) u_ch (
      .clk_sys (clk_sys),
      .rst_n   (rst_n),
      .cen     (pxl_cen),
      .fc      (s1_fc),
      .mode    (s1_mode),
      .blank   (s1_blank),
      .cur     (s1_cur [(CH-i)*DW-1 -: DW]),
      .prev    (s1_prev[(CH-i)*DW-1 -: DW]),
      .dout    (rgb_out[(CH-i)*DW-1 -: DW])
    );
  end

endmodule

// File: tb/tb_jtframe_rgb_interp_pipe.sv
// Scoreboard bench for the RGB interpolator: stimulus pushes expected pixels
// tagged with the cen edge they must appear after; a monitor pops and checks.
module tb_jtframe_rgb_interp_pipe;

  localparam int CH = 3;
  localparam int DW = 8;
  localparam int FW = 8;
  localparam int BW = CH * DW;

  logic          clk_sys;
  logic          rst_n;
  logic          pxl_cen;
  logic          in_valid;
  logic          blank;
  logic [1:0]    mode;
  logic [FW:0]   frac;
  logic [BW-1:0] rgb_in;
  logic [BW-1:0] rgb_in_prev;
  logic [BW-1:0] rgb_out;
  logic          out_valid;
  logic          out_blank;

  typedef struct {
    logic [BW-1:0] rgb;
    logic          blk;
    int            idx;
    string         name;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cen_idx = 0;
  int            gap = 1;
  bit            rst_seen = 1'b1;
  logic [BW-1:0] snap_rgb = '0;
  logic          snap_valid = 1'b0;
  logic          snap_blank = 1'b0;

  jtframe_rgb_interp_pipe #(
    .CH (CH),
    .DW (DW),
    .FW (FW)
  ) dut (
    .clk_sys     (clk_sys),
    .rst_n       (rst_n),
    .pxl_cen     (pxl_cen),
    .in_valid    (in_valid),
    .blank       (blank),
    .mode        (mode),
    .frac        (frac),
    .rgb_in      (rgb_in),
    .rgb_in_prev (rgb_in_prev),
    .rgb_out     (rgb_out),
    .out_valid   (out_valid),
    .out_blank   (out_blank)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Reference blend for the frac sweep, straight from the weighting formula.
  function automatic logic [BW-1:0] modelLin(input int f, input logic [BW-1:0] cur,
                                             input logic [BW-1:0] prv);
    logic [BW-1:0] r;
    int fc, c, p, v;
    r  = '0;
    fc = (f > 256) ? 256 : f;
    for (int i = 0; i < CH; i++) begin
      c = int'(cur[(CH-1-i)*DW +: DW]);
      p = int'(prv[(CH-1-i)*DW +: DW]);
      v = (p * (256 - fc) + c * fc + 128) >> 8;
      if (v > 255) v = 255;
      r[(CH-1-i)*DW +: DW] = v[7:0];
    end
    return r;
  endfunction

  // Drive one pixel on a cen edge, queue its expectation, then idle gap-1 cycles
  // with scrambled inputs that must not be captured.
  task automatic applyStimulus(input string name, input logic v, input logic b,
                               input logic [1:0] m, input logic [FW:0] f,
                               input logic [BW-1:0] cur, input logic [BW-1:0] prv,
                               input logic [BW-1:0] exp_rgb);
    exp_t e;
    @(negedge clk_sys);
    in_valid    = v;
    blank       = b;
    mode        = m;
    frac        = f;
    rgb_in      = cur;
    rgb_in_prev = prv;
    pxl_cen     = 1'b1;
    if (v) begin
      e.rgb  = exp_rgb;
      e.blk  = b;
      e.idx  = cen_idx + 3;
      e.name = name;
      q.push_back(e);
    end
    for (int i = 1; i < gap; i++) begin
      @(negedge clk_sys);
      pxl_cen     = 1'b0;
      in_valid    = 1'($urandom);
      blank       = 1'($urandom);
      mode        = 2'($urandom);
      frac        = (FW+1)'($urandom);
      rgb_in      = BW'($urandom);
      rgb_in_prev = BW'($urandom);
    end
  endtask

  // Compare the outputs after a cen edge against the head of the scoreboard.
  task automatic checkOutput();
    exp_t e;
    bit   exp_valid;
    exp_valid = (q.size() > 0) && (q[0].idx == cen_idx);
    total++;
    if (out_valid !== exp_valid) begin
      bad++;
      $display("[TB] FAIL valid at cen %0d: got=%b exp=%b", cen_idx, out_valid, exp_valid);
    end
    if (exp_valid) begin
      e = q.pop_front();
      total++;
      if (rgb_out !== e.rgb) begin
        bad++;
        $display("[TB] FAIL rgb %s: got=%h exp=%h", e.name, rgb_out, e.rgb);
      end
      total++;
      if (out_blank !== e.blk) begin
        bad++;
        $display("[TB] FAIL blank %s: got=%b exp=%b", e.name, out_blank, e.blk);
      end
    end
    while (q.size() > 0 && q[0].idx < cen_idx) void'(q.pop_front());
  endtask

  // Monitor: check on cen edges, and confirm outputs hold on non-cen edges.
  always @(posedge clk_sys) begin
    logic cen_now;
    logic rst_now;
    cen_now = pxl_cen;
    rst_now = rst_n;
    #1;
    if (rst_now && cen_now) begin
      cen_idx++;
      checkOutput();
    end else if (rst_now && !rst_seen) begin
      total++;
      if ({rgb_out, out_valid, out_blank} !== {snap_rgb, snap_valid, snap_blank}) begin
        bad++;
        $display("[TB] FAIL hold: got=%h/%b/%b exp=%h/%b/%b", rgb_out, out_valid,
                 out_blank, snap_rgb, snap_valid, snap_blank);
      end
    end
    snap_rgb   = rgb_out;
    snap_valid = out_valid;
    snap_blank = out_blank;
    rst_seen   = 1'b0;
  end

  // Assert reset between clock edges and check the outputs clear at once.
  task automatic doReset();
    @(posedge clk_sys);
    #3;
    rst_n    = 1'b0;
    rst_seen = 1'b1;
    #1;
    total++;
    if ({rgb_out, out_valid, out_blank} !== '0) begin
      bad++;
      $display("[TB] FAIL async_reset: got=%h/%b/%b exp=0/0/0", rgb_out, out_valid, out_blank);
    end
    q.delete();
    repeat (2) begin
      @(negedge clk_sys);
      in_valid = 1'b0;
      pxl_cen  = 1'b1;
    end
    @(negedge clk_sys);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int n);
    repeat (n) begin
      @(negedge clk_sys);
      in_valid = 1'b0;
      pxl_cen  = 1'b1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got=running exp=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst_n       = 1'b0;
    pxl_cen     = 1'b0;
    in_valid    = 1'b0;
    blank       = 1'b0;
    mode        = 2'd0;
    frac        = '0;
    rgb_in      = '0;
    rgb_in_prev = '0;
    #2;
    total++;
    if ({rgb_out, out_valid, out_blank} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_state: got=%h/%b/%b exp=0/0/0", rgb_out, out_valid, out_blank);
    end
    repeat (2) @(negedge clk_sys);
    rst_n = 1'b1;

    // Back-to-back pixels, cen tied high.
    gap = 1;
    applyStimulus("lin_mid",    1, 0, 2'd0, 9'd128, 24'hFFFFFF, 24'h000000, 24'h808080);
    applyStimulus("lin_f0",     1, 0, 2'd0, 9'd0,   24'hA0B0C0, 24'h102030, 24'h102030);
    applyStimulus("lin_f256",   1, 0, 2'd0, 9'd256, 24'hA0B0C0, 24'h102030, 24'hA0B0C0);
    applyStimulus("lin_f511",   1, 0, 2'd0, 9'd511, 24'hA0B0C0, 24'h102030, 24'hA0B0C0);
    applyStimulus("invalid",    0, 0, 2'd0, 9'd77,  24'h123456, 24'h654321, 24'h000000);
    applyStimulus("lin_f255",   1, 0, 2'd0, 9'd255, 24'hFFFFFF, 24'h000000, 24'hFEFEFE);
    applyStimulus("lin_mix",    1, 0, 2'd0, 9'd128, 24'h102030, 24'h302010, 24'h202020);
    applyStimulus("mode3",      1, 0, 2'd3, 9'd64,  24'hFF0080, 24'h00FF80, 24'h40BF80);
    applyStimulus("near_127",   1, 0, 2'd1, 9'd127, 24'hAAAAAA, 24'h111111, 24'h111111);
    applyStimulus("near_128",   1, 0, 2'd1, 9'd128, 24'hAAAAAA, 24'h111111, 24'hAAAAAA);
    applyStimulus("near_clamp", 1, 0, 2'd1, 9'd300, 24'hAAAAAA, 24'h111111, 24'hAAAAAA);
    applyStimulus("blank",      1, 1, 2'd0, 9'd200, 24'hFFFFFF, 24'h123456, 24'h000000);
    applyStimulus("bypass",     1, 0, 2'd2, 9'd0,   24'h123456, 24'hABCDEF, 24'h123456);
    applyStimulus("bypass_f511",1, 0, 2'd2, 9'd511, 24'h654321, 24'h000000, 24'h654321);

    // Weight sweep across the full range, independent channel values.
    for (int f = 0; f <= 256; f += 32) begin
      applyStimulus("sweep", 1, 0, 2'd0, (FW+1)'(f), 24'hF03705, 24'h0AC8FF,
                    modelLin(f, 24'hF03705, 24'h0AC8FF));
    end

    // Pixel clock enable one cycle in four; inputs churn while cen is low.
    gap = 4;
    applyStimulus("gap_lin",    1, 0, 2'd0, 9'd128, 24'hFFFFFF, 24'h000000, 24'h808080);
    applyStimulus("gap_near",   1, 0, 2'd1, 9'd128, 24'hAAAAAA, 24'h111111, 24'hAAAAAA);
    applyStimulus("gap_inval",  0, 0, 2'd0, 9'd10,  24'h111111, 24'h222222, 24'h000000);
    applyStimulus("gap_blank",  1, 1, 2'd2, 9'd0,   24'hFFFFFF, 24'hFFFFFF, 24'h000000);
    applyStimulus("gap_bypass", 1, 0, 2'd2, 9'd0,   24'h123456, 24'h000000, 24'h123456);
    applyStimulus("gap_mix",    1, 0, 2'd3, 9'd64,  24'hFF0080, 24'h00FF80, 24'h40BF80);
    drain(4);

    // Reset with pixels in flight; none of them may reappear afterwards.
    gap = 1;
    applyStimulus("flight_a",   1, 0, 2'd2, 9'd0,   24'h0A0B0C, 24'h000000, 24'h0A0B0C);
    applyStimulus("flight_b",   1, 0, 2'd2, 9'd0,   24'h1A1B1C, 24'h000000, 24'h1A1B1C);
    applyStimulus("flight_c",   1, 0, 2'd2, 9'd0,   24'h2A2B2C, 24'h000000, 24'h2A2B2C);
    doReset();
    drain(3);
    gap = 4;
    applyStimulus("post_reset", 1, 0, 2'd0, 9'd128, 24'hFFFFFF, 24'h000000, 24'h808080);
    drain(6);

    @(negedge clk_sys);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("[TB] FAIL leftover: got=%0d pending exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
